// File: rtl/sm83_bus_arbiter.sv
// sm83_bus_arbiter
//
// Shares the single external memory bus between the SM83 core and the two DMA
// engines (HDMA and OAM DMA). The bus is divided into fixed 4-clock M-cycle
// slots. At the edge that ends T-phase 3 the arbiter picks the highest-priority
// pending requester (HDMA > OAM DMA > CPU), latches its request, and drives
// the bus for the following four clocks.
//
// Handshake: a requester holds req_i[n] together with its addr/wdata/we stable
// until it sees gnt_o[n] (a one-cycle pulse in T-phase 0). Requests are sampled
// only at the edge ending T-phase 3. done_o[n] pulses exactly four cycles after
// gnt_o[n]; for reads, rdata_o is valid in that cycle and holds until the next
// read completes.
//
// Ports:
//   clk_i          T-cycle clock
//   rst_i          asynchronous active-high reset
//   req_i[2:0]     requests: bit0 HDMA, bit1 OAM DMA, bit2 CPU
//   *_addr_i       per-requester address
//   *_wdata_i      per-requester write data
//   we_i[2:0]      per-requester write enable (1 = write)
//   gnt_o[2:0]     one-hot grant pulse (T-phase 0)
//   done_o[2:0]    one-hot completion pulse (T-phase 0 of the next slot)
//   rdata_o        read data of the last completed read
//   bus_addr_o     bus address (held while idle)
//   bus_wdata_o    bus write data (T-phases 1..2 of a write, else 0)
//   bus_re_o       bus read strobe (whole slot of a read)
//   bus_we_o       bus write strobe (T-phases 1..2 of a write)
//   bus_rdata_i    bus read data, sampled at the edge ending T-phase 3
//   tphase_o       current T-phase 0..3

module sm83_bus_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [2:0]        req_i,
  input  logic [ADDR_W-1:0] hdma_addr_i,
  input  logic [ADDR_W-1:0] oam_addr_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] hdma_wdata_i,
  input  logic [DATA_W-1:0] oam_wdata_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  input  logic [2:0]        we_i,
  output logic [2:0]        gnt_o,
  output logic [2:0]        done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic              bus_re_o,
  output logic              bus_we_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic [1:0]        tphase_o
);

  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;

  localparam logic [1:0] OWN_HDMA = 2'd0;
  localparam logic [1:0] OWN_OAM  = 2'd1;
  localparam logic [1:0] OWN_CPU  = 2'd2;

  // Slot state
  logic [1:0]        ph_q, ph_d;
  logic              slot_active_q, slot_active_d;
  logic [1:0]        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;

  // Registered outputs
  logic [2:0]        gnt_q, gnt_d;
  logic [2:0]        done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              bus_re_q, bus_re_d;
  logic              bus_we_q, bus_we_d;

  // Fixed-priority winner of the current request vector
  logic              win_valid;
  logic [1:0]        win_owner;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_we;

  always_comb begin
    win_valid = 1'b1;
    win_owner = OWN_HDMA;
    win_addr  = hdma_addr_i;
    win_wdata = hdma_wdata_i;
    win_we    = we_i[0];
    if (req_i[0]) begin
      win_owner = OWN_HDMA;
    end else if (req_i[1]) begin
      win_owner = OWN_OAM;
      win_addr  = oam_addr_i;
      win_wdata = oam_wdata_i;
      win_we    = we_i[1];
    end else if (req_i[2]) begin
      win_owner = OWN_CPU;
      win_addr  = cpu_addr_i;
      win_wdata = cpu_wdata_i;
      win_we    = we_i[2];
    end else begin
      win_valid = 1'b0;
    end
  end

  always_comb begin
    ph_d          = ph_q + 2'd1;
    slot_active_d = slot_active_q;
    owner_d       = owner_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    we_d          = we_q;
    gnt_d         = 3'b000;
    done_d        = 3'b000;
    rdata_d       = rdata_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    bus_re_d      = bus_re_q;
    bus_we_d      = bus_we_q;

    case (ph_q)
      PH0: begin
        // Write strobe and data occupy T-phases 1..2 only.
        if (slot_active_q && we_q) begin
          bus_we_d    = 1'b1;
          bus_wdata_d = wdata_q;
        end
      end
      PH2: begin
        bus_we_d    = 1'b0;
        bus_wdata_d = '0;
      end
      PH3: begin
        // Close the current slot: completion and read capture.
        if (slot_active_q) begin
          done_d = 3'b001 << owner_q;
          if (!we_q) rdata_d = bus_rdata_i;
        end
        // Open the next slot.
        slot_active_d = win_valid;
        if (win_valid) begin
          owner_d    = win_owner;
          addr_d     = win_addr;
          wdata_d    = win_wdata;
          we_d       = win_we;
          gnt_d      = 3'b001 << win_owner;
          bus_addr_d = win_addr;
          bus_re_d   = !win_we;
        end else begin
          bus_re_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ph_q          <= PH0;
      slot_active_q <= 1'b0;
      owner_q       <= OWN_HDMA;
      addr_q        <= '0;
      wdata_q       <= '0;
      we_q          <= 1'b0;
      gnt_q         <= 3'b000;
      done_q        <= 3'b000;
      rdata_q       <= '0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      bus_re_q      <= 1'b0;
      bus_we_q      <= 1'b0;
    end else begin
      ph_q          <= ph_d;
      slot_active_q <= slot_active_d;
      owner_q       <= owner_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      we_q          <= we_d;
      gnt_q         <= gnt_d;
      done_q        <= done_d;
      rdata_q       <= rdata_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      bus_re_q      <= bus_re_d;
      bus_we_q      <= bus_we_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign rdata_o     = rdata_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_re_o    = bus_re_q;
  assign bus_we_o    = bus_we_q;
  assign tphase_o    = ph_q;

endmodule

// File: tb/tb_sm83_bus_arbiter.sv
module tb_sm83_bus_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  req = 3'b000;
  logic [15:0] hdma_addr = '0, oam_addr = '0, cpu_addr = '0;
  logic [7:0]  hdma_wdata = '0, oam_wdata = '0, cpu_wdata = '0;
  logic [2:0]  we = 3'b000;
  logic [7:0]  bus_rdata = '0;

  logic [2:0]  gnt_o, done_o;
  logic [7:0]  rdata_o, bus_wdata_o;
  logic [15:0] bus_addr_o;
  logic        bus_re_o, bus_we_o;
  logic [1:0]  tphase_o;

  sm83_bus_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req),
    .hdma_addr_i(hdma_addr), .oam_addr_i(oam_addr), .cpu_addr_i(cpu_addr),
    .hdma_wdata_i(hdma_wdata), .oam_wdata_i(oam_wdata), .cpu_wdata_i(cpu_wdata),
    .we_i(we), .gnt_o(gnt_o), .done_o(done_o), .rdata_o(rdata_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_re_o(bus_re_o), .bus_we_o(bus_we_o),
    .bus_rdata_i(bus_rdata), .tphase_o(tphase_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- slot-level reference model ----------------
  // The model tracks the phase of the current cycle and the access that owns
  // the current and previous slot; every observable output follows from these.
  typedef struct packed {
    logic        active;
    logic [1:0]  owner;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
  } slot_t;

  int          m_ph;
  slot_t       m_cur, m_prev;
  logic [7:0]  m_rdata;
  logic [15:0] m_bus_addr;

  task automatic model_reset();
    m_ph = 0;
    m_cur = '0;
    m_prev = '0;
    m_rdata = '0;
    m_bus_addr = '0;
  endtask

  // Applies the inputs driven during the current cycle at the coming edge.
  task automatic model_commit();
    if (m_ph == 3) begin
      if (m_cur.active && !m_cur.we) m_rdata = bus_rdata;
      m_prev = m_cur;
      m_cur = '0;
      if (req[0])      m_cur = '{1'b1, 2'd0, hdma_addr, hdma_wdata, we[0]};
      else if (req[1]) m_cur = '{1'b1, 2'd1, oam_addr, oam_wdata, we[1]};
      else if (req[2]) m_cur = '{1'b1, 2'd2, cpu_addr, cpu_wdata, we[2]};
      if (m_cur.active) m_bus_addr = m_cur.addr;
    end
    m_ph = (m_ph + 1) % 4;
  endtask

  function automatic logic [41:0] model_exp();
    logic [2:0] g, d;
    logic       re, wr;
    logic [7:0] wd;
    g  = (m_ph == 0 && m_cur.active)  ? (3'b001 << m_cur.owner)  : 3'b000;
    d  = (m_ph == 0 && m_prev.active) ? (3'b001 << m_prev.owner) : 3'b000;
    re = m_cur.active && !m_cur.we;
    wr = m_cur.active && m_cur.we && (m_ph == 1 || m_ph == 2);
    wd = wr ? m_cur.wdata : 8'h00;
    return {m_ph[1:0], g, d, m_rdata, m_bus_addr, wd, re, wr};
  endfunction

  function automatic logic [41:0] pack_dut();
    return {tphase_o, gnt_o, done_o, rdata_o, bus_addr_o, bus_wdata_o, bus_re_o, bus_we_o};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic advance();
    model_commit();
    @(negedge clk);
  endtask

  task automatic align(input int p);
    for (int i = 0; i < 4 && m_ph != p; i++) advance();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    n_vec++;
    if (pack_dut() !== 42'd0) begin
      n_err++; $display("FAIL reset_hold dut=%h exp=%h", pack_dut(), 42'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    n_vec++;
    if (pack_dut() !== model_exp()) begin
      n_err++; $display("FAIL reset_release dut=%h exp=%h", pack_dut(), model_exp());
    end
  endtask

  task automatic test_cpu_read();
    int gnt_at = -1, done_at = -1;
    logic [7:0] rd_at_done = 8'h00;
    align(1);
    req = 3'b100; cpu_addr = 16'hC000; we = 3'b000; bus_rdata = 8'h5A;
    for (int i = 1; i <= 10; i++) begin
      advance();
      n_vec++;
      if (pack_dut() !== model_exp()) begin
        n_err++; $display("FAIL cpu_read cyc=%0d dut=%h exp=%h", i, pack_dut(), model_exp());
      end
      if (gnt_o == 3'b100 && gnt_at < 0) begin gnt_at = i; req = 3'b000; end
      if (done_o == 3'b100 && done_at < 0) begin done_at = i; rd_at_done = rdata_o; end
    end
    n_vec++;
    if (gnt_at != 3 || done_at != 7 || rd_at_done !== 8'h5A) begin
      n_err++;
      $display("FAIL cpu_read_timing gnt_at=%0d done_at=%0d rdata=%h exp 3 7 5a", gnt_at, done_at, rd_at_done);
    end
  endtask

  task automatic test_cpu_write();
    int we_cycles = 0, re_cycles = 0;
    logic [7:0] rd_before;
    rd_before = rdata_o;
    align(3);
    req = 3'b100; cpu_addr = 16'hFF40; cpu_wdata = 8'h91; we = 3'b100;
    for (int i = 1; i <= 9; i++) begin
      advance();
      n_vec++;
      if (pack_dut() !== model_exp()) begin
        n_err++; $display("FAIL cpu_write cyc=%0d dut=%h exp=%h", i, pack_dut(), model_exp());
      end
      if (gnt_o[2]) req = 3'b000;
      if (bus_we_o && bus_wdata_o == 8'h91 && (tphase_o == 2'd1 || tphase_o == 2'd2)) we_cycles++;
      if (bus_re_o) re_cycles++;
    end
    we = 3'b000;
    n_vec++;
    if (we_cycles != 2 || re_cycles != 0 || rdata_o !== rd_before) begin
      n_err++;
      $display("FAIL cpu_write_strobes we_cyc=%0d re_cyc=%0d rdata=%h exp 2 0 %h", we_cycles, re_cycles, rdata_o, rd_before);
    end
  endtask

  task automatic test_priority();
    int cpu_gnts = 0;
    logic [2:0] order [3];
    int k = 0;
    align(3);
    req = 3'b111; we = 3'b000;
    hdma_addr = 16'h8000; oam_addr = 16'hFE00; cpu_addr = 16'hC100;
    for (int i = 1; i <= 36; i++) begin
      bus_rdata = 8'($urandom);
      advance();
      n_vec++;
      if (pack_dut() !== model_exp()) begin
        n_err++; $display("FAIL priority cyc=%0d dut=%h exp=%h", i, pack_dut(), model_exp());
      end
      if (i <= 12 && gnt_o[2]) cpu_gnts++;
      if (gnt_o != 3'b000 && (i == 9 || i == 21 || i == 33)) begin order[k] = gnt_o; k++; end
      if (i == 12) req = 3'b110;
      if (i == 24) req = 3'b100;
    end
    req = 3'b000;
    n_vec++;
    if (cpu_gnts != 0 || k != 3 || order[0] !== 3'b001 || order[1] !== 3'b010 || order[2] !== 3'b100) begin
      n_err++;
      $display("FAIL priority_order cpu_gnts=%0d k=%0d seq=%b/%b/%b exp 0 3 001/010/100",
               cpu_gnts, k, order[0], order[1], order[2]);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q[$];
    logic [15:0] addrs [3];
    int k = 0, last_gnt = -1, bad_gap = 0;
    addrs[0] = 16'hD000; addrs[1] = 16'hD123; addrs[2] = 16'hDFFF;
    for (int j = 0; j < 3; j++) exp_q.push_back(addrs[j]);
    align(3);
    req = 3'b100; we = 3'b000; cpu_addr = addrs[0];
    for (int i = 1; i <= 14; i++) begin
      bus_rdata = 8'($urandom);
      advance();
      n_vec++;
      if (pack_dut() !== model_exp()) begin
        n_err++; $display("FAIL b2b cyc=%0d dut=%h exp=%h", i, pack_dut(), model_exp());
      end
      if (gnt_o[2]) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL b2b_extra_gnt cyc=%0d addr=%h exp none", i, bus_addr_o);
        end else if (bus_addr_o !== exp_q[0]) begin
          n_err++; $display("FAIL b2b_addr cyc=%0d dut=%h exp=%h", i, bus_addr_o, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
        if (last_gnt >= 0 && i - last_gnt != 4) bad_gap++;
        if (last_gnt >= 0 && done_o !== 3'b100) bad_gap++;
        last_gnt = i;
        k++;
        if (k < 3) cpu_addr = addrs[k]; else req = 3'b000;
      end
    end
    n_vec++;
    if (exp_q.size() != 0 || bad_gap != 0) begin
      n_err++; $display("FAIL b2b_cadence left=%0d bad_gap=%0d exp 0 0", exp_q.size(), bad_gap);
    end
  endtask

  task automatic test_reset_mid_slot();
    int done_seen = 0;
    align(1);
    req = 3'b010; oam_addr = 16'hFE10; we = 3'b000;
    for (int i = 0; i < 4 && !gnt_o[1]; i++) advance();
    req = 3'b000;
    align(2);
    n_vec++;
    if (!(bus_re_o && tphase_o == 2'd2 && bus_addr_o == 16'hFE10)) begin
      n_err++; $display("FAIL rst_mid_setup re=%b ph=%0d addr=%h exp 1 2 fe10", bus_re_o, tphase_o, bus_addr_o);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (pack_dut() !== 42'd0) begin
      n_err++; $display("FAIL rst_mid_clear dut=%h exp=%h", pack_dut(), 42'd0);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (pack_dut() !== model_exp()) begin
      n_err++; $display("FAIL rst_mid_release dut=%h exp=%h", pack_dut(), model_exp());
    end
    req = 3'b010; oam_addr = 16'hFE20;
    for (int i = 1; i <= 10; i++) begin
      bus_rdata = 8'($urandom);
      advance();
      n_vec++;
      if (pack_dut() !== model_exp()) begin
        n_err++; $display("FAIL rst_mid_reissue cyc=%0d dut=%h exp=%h", i, pack_dut(), model_exp());
      end
      if (gnt_o[1]) req = 3'b000;
      if (done_o != 3'b000) done_seen++;
    end
    n_vec++;
    if (done_seen != 1) begin
      n_err++; $display("FAIL rst_mid_done_count dut=%0d exp=1", done_seen);
    end
  endtask

  task automatic test_idle();
    logic [15:0] addr_hold;
    int activity = 0;
    req = 3'b000;
    align(3);
    advance();
    addr_hold = m_bus_addr;
    for (int i = 1; i <= 8; i++) begin
      advance();
      n_vec++;
      if (pack_dut() !== model_exp()) begin
        n_err++; $display("FAIL idle cyc=%0d dut=%h exp=%h", i, pack_dut(), model_exp());
      end
      if (bus_re_o || bus_we_o || gnt_o != 3'b000 || done_o != 3'b000) activity++;
      if (i >= 5 && bus_addr_o !== addr_hold) activity++;
    end
    n_vec++;
    if (activity != 0) begin
      n_err++; $display("FAIL idle_quiet activity=%0d exp=0", activity);
    end
  endtask

  task automatic test_random();
    for (int i = 1; i <= 400; i++) begin
      req        = 3'($urandom_range(0, 7));
      we         = 3'($urandom_range(0, 7));
      hdma_addr  = 16'($urandom);
      oam_addr   = 16'($urandom);
      cpu_addr   = 16'($urandom);
      hdma_wdata = 8'($urandom);
      oam_wdata  = 8'($urandom);
      cpu_wdata  = 8'($urandom);
      bus_rdata  = 8'($urandom);
      advance();
      n_vec++;
      if (pack_dut() !== model_exp()) begin
        n_err++; $display("FAIL random cyc=%0d dut=%h exp=%h", i, pack_dut(), model_exp());
      end
    end
    req = 3'b000;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_priority();
    test_back_to_back();
    test_reset_mid_slot();
    test_idle();
    test_random();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sm83_bus_arbiter.md
# sm83_bus_arbiter

- Shares the single external memory bus between the SM83 core and the two DMA engines: HDMA (VRAM DMA) and OAM DMA.
- Sits between the core's control unit and the memory map.
- Carves the bus into fixed 4-clock M-cycle slots and grants each slot to the highest-priority pending requester.
- Drives the bus for that slot and returns read data plus a completion pulse to the owner.

## Interface

Parameters:
- ADDR_W, 16, bus address width
- DATA_W, 8, bus data width

Ports:
- clk_i  in  1  T-cycle clock; the only clock.
- rst_i  in  1  Asynchronous, active-high reset.
- req_i  in  3  Request per requester. Bit 0 = HDMA, bit 1 = OAM DMA, bit 2 = CPU.
- hdma_addr_i / oam_addr_i / cpu_addr_i  in  ADDR_W each  Request address.
- hdma_wdata_i / oam_wdata_i / cpu_wdata_i  in  DATA_W each  Write data.
- we_i  in  3  Per-requester write enable. 1 = write, 0 = read.
- gnt_o  out  3  One-hot grant pulse; one cycle long.
- done_o  out  3  One-hot completion pulse; one cycle long.
- rdata_o  out  DATA_W  Read data. Valid while the matching done_o is high.
- bus_addr_o  out  ADDR_W  Bus address.
- bus_wdata_o  out  DATA_W  Bus write data.
- bus_re_o  out  1  Bus read strobe.
- bus_we_o  out  1  Bus write strobe.
- bus_rdata_i  in  DATA_W  Bus read data.
- tphase_o  out  2  Current T-phase, 0..3.

## Operation

- **Phase counter:** ph is free-running, 0→1→2→3→0, and starts at 0 after reset. tphase_o = ph.
- **State:** slot_active (1 bit), owner (2 bits), plus latched addr, wdata and we.
- **Arbitration:** evaluated at the rising edge that ends ph==3.
  - Fixed priority: HDMA > OAM DMA > CPU. No fairness; a lower-priority requester may starve.
  - Winner found: latch the winner's addr/wdata/we, set owner, slot_active=1, and set gnt_o[owner]=1 for the coming ph0.
  - No request pending: slot_active=0 and the bus is idle for the whole slot.
- **Requester obligations:**
  - Hold req_i, addr, wdata and we stable from assertion until gnt_o is seen.
  - Deassert req_i in the gnt cycle for a single access, or keep it high to request again.
  - Inputs are ignored after the latch, so changing them mid-slot has no effect.
- **Active slot:**
  - bus_addr_o = latched addr during ph0..ph3.
  - bus_re_o = !we during ph0..ph3.
  - bus_wdata_o = latched wdata and bus_we_o = we, both during ph1..ph2 only.
  - Sample bus_rdata_i into rdata_o at the edge ending ph3 (reads only).
  - done_o[owner] pulses in the next ph0, coincident with any new gnt_o.
- **Idle slot:** bus_re_o = bus_we_o = 0 and bus_addr_o holds its last value. No done_o.
- **Outputs:** all outputs are registered; none depends combinationally on req_i.
- **rdata_o** holds its value until the next read completes. After a write it is unchanged.

## Timing

- **Reset values:** ph=0, slot_active=0, owner=0, gnt_o=0, done_o=0, rdata_o=0, bus_addr_o=0, bus_wdata_o=0, bus_re_o=0, bus_we_o=0.
- **Request to grant:** a request first present during ph=k is granted in the next ph0, i.e. latency 4−k cycles (1 to 4).
  - A request raised exactly in ph3 is still arbitrated at that ph3 edge.
- **Grant to done:** done_o pulses exactly 4 cycles after gnt_o. Bus occupancy is 4 cycles per access.
- **Back-to-back:** with continuous req_i, one access per 4 cycles. The new gnt_o and the previous done_o overlap in the same ph0.
- **Simultaneous requests:** only the highest-priority winner is granted. The losers keep waiting with no gnt_o and no done_o.
- **Reset mid-slot:**
  - Asynchronous; all state clears immediately and bus_re_o/bus_we_o drop within the same cycle.
  - The in-flight access is abandoned and no done_o is issued.
  - Requesters must reissue after reset.
- **Preemption:** a higher-priority request arriving mid-slot never preempts the owner. It wins the next slot.

## Test plan

- **Single CPU read:** req_i=3'b100, cpu_addr_i=16'hC000 at ph1, bus_rdata_i=8'h5A.
  - gnt_o=3'b100 at the next ph0 (3 cycles later).
  - bus_addr_o=C000 with bus_re_o=1 for 4 cycles.
  - done_o=3'b100 and rdata_o=5A 4 cycles after grant.
- **CPU write:** cpu_addr_i=16'hFF40, wdata=8'h91, we=1.
  - bus_we_o=1 only in ph1 and ph2, with bus_wdata_o=91.
  - bus_re_o=0 throughout; rdata_o unchanged.
- **Priority collision:** req_i=3'b111 held.
  - Grants go to HDMA on every slot and the CPU gets no gnt_o.
  - Drop HDMA → OAM DMA is granted next slot. Drop OAM DMA → CPU is granted.
- **Back-to-back:** CPU holds req with 3 different addresses.
  - gnt_o appears every 4 cycles.
  - Each done_o coincides with the next gnt_o, and addresses appear on the bus in order.
- **Reset during ph2 of an OAM DMA read:**
  - All outputs go to 0 immediately and no done_o is issued.
  - After release, ph restarts at 0 and the reissued request is granted normally.
- **Idle slot:** req_i=0 for 8 cycles.
  - No strobes, gnt_o or done_o.
  - bus_addr_o holds its last value and tphase_o keeps cycling 0..3.
